// File: rtl/gpr_ctrl_pkg.sv
// Shared op/select encodings, sequencer states and default widths for the
// GPR access controller.
package gpr_ctrl_pkg;

    localparam int GPR_DATA_W = 16;
    localparam int GPR_CNT_W  = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_MOVE  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        SEL_X   = 2'd0,
        SEL_Y   = 2'd1,
        SEL_ACC = 2'd2,
        SEL_BAD = 2'd3
    } sel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_MOVE_RD,
        S_MOVE_WR,
        S_CLEAR,
        S_RESP
    } state_t;

    // CLEAR ignores both selects, so it can never be rejected.
    function automatic logic cmd_invalid(input logic [1:0] op,
                                         input logic [1:0] dst,
                                         input logic [1:0] src);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_WRITE: bad = (dst == SEL_BAD);
            OP_READ:  bad = (src == SEL_BAD);
            OP_MOVE:  bad = (dst == SEL_BAD) || (src == SEL_BAD);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/gpr_sel_decode.sv
// Register select to one-hot strobe decoder; bit 0=X, 1=Y, 2=ACC.
module gpr_sel_decode
    import gpr_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [1:0] sel,
    output logic [2:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            case (sel)
                SEL_X:   onehot = 3'b001;
                SEL_Y:   onehot = 3'b010;
                SEL_ACC: onehot = 3'b100;
                default: onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/gpr_access_controller.sv
// Sequences write/read/move/clear commands onto the X/Y/ACC register file
// port and returns a handshaked response with read data or an error flag.
module gpr_access_controller
    import gpr_ctrl_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int CNT_W  = GPR_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_dst,
    input  logic [1:0]        cmd_src,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write_x,
    output logic              rf_write_y,
    output logic              rf_write_acc,
    output logic              rf_read_x,
    output logic              rf_read_y,
    output logic              rf_read_acc,
    input  logic [DATA_W-1:0] rf_data_x,
    input  logic [DATA_W-1:0] rf_data_y,
    input  logic [DATA_W-1:0] rf_data_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  txn_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            nxt_state;
    logic [1:0]        dst_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] hold_q;
    logic [2:0]        wr_q;
    logic [2:0]        rd_q;

    logic              wr_en_n;
    logic [1:0]        wr_sel_n;
    logic              rd_en_n;
    logic [1:0]        rd_sel_n;
    logic              clr_n;
    logic              err_n;
    logic [2:0]        wr_oh_n;
    logic [2:0]        rd_oh_n;
    logic [DATA_W-1:0] rd_val;

    // Strobes for the coming cycle are decoded from next-state information so
    // they can be registered and still land in the cycle after acceptance.
    always_comb begin
        nxt_state = state;
        wr_en_n   = 1'b0;
        wr_sel_n  = dst_q;
        rd_en_n   = 1'b0;
        rd_sel_n  = cmd_src;
        clr_n     = 1'b0;
        err_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_invalid(cmd_op, cmd_dst, cmd_src)) begin
                        err_n     = 1'b1;
                        nxt_state = S_RESP;
                    end else begin
                        case (cmd_op)
                            OP_WRITE: begin
                                nxt_state = S_WRITE;
                                wr_en_n   = 1'b1;
                                wr_sel_n  = cmd_dst;
                            end
                            OP_READ: begin
                                nxt_state = S_READ;
                                rd_en_n   = 1'b1;
                            end
                            OP_MOVE: begin
                                nxt_state = S_MOVE_RD;
                                rd_en_n   = 1'b1;
                            end
                            default: begin
                                nxt_state = S_CLEAR;
                                clr_n     = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_MOVE_RD: begin
                nxt_state = S_MOVE_WR;
                wr_en_n   = 1'b1;
            end
            S_WRITE, S_READ, S_MOVE_WR, S_CLEAR: nxt_state = S_RESP;
            S_RESP: if (rsp_ready) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    gpr_sel_decode u_wr_dec (
        .en     (wr_en_n),
        .sel    (wr_sel_n),
        .onehot (wr_oh_n)
    );

    gpr_sel_decode u_rd_dec (
        .en     (rd_en_n),
        .sel    (rd_sel_n),
        .onehot (rd_oh_n)
    );

    always_comb begin
        rd_val = '0;
        if (rd_q[0])      rd_val = rf_data_x;
        else if (rd_q[1]) rd_val = rf_data_y;
        else if (rd_q[2]) rd_val = rf_data_acc;
    end

    always_comb begin
        case (state)
            S_WRITE:   rf_data_in = data_q;
            S_MOVE_WR: rf_data_in = hold_q;
            default:   rf_data_in = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            dst_q     <= '0;
            data_q    <= '0;
            hold_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            state     <= nxt_state;
            cmd_ready <= (nxt_state == S_IDLE);
            wr_q      <= clr_n ? 3'b111 : wr_oh_n;
            rd_q      <= rd_oh_n;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dst_q  <= cmd_dst;
                        data_q <= cmd_data;
                        if (err_n) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                S_READ: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= rd_val;
                    rsp_err   <= 1'b0;
                end
                S_MOVE_RD: hold_q <= rd_val;
                S_WRITE, S_MOVE_WR, S_CLEAR: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        txn_count <= txn_count + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {rf_write_acc, rf_write_y, rf_write_x} = wr_q;
    assign {rf_read_acc,  rf_read_y,  rf_read_x}  = rd_q;

    a_rd_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(rd_q));
    a_wr_shape:  assert property (@(posedge clk) disable iff (!rst)
                                  $onehot0(wr_q) || (wr_q == 3'b111));
    a_din_idle:  assert property (@(posedge clk) disable iff (!rst)
                                  (wr_q == 3'b000) |-> (rf_data_in == '0));

endmodule
